// File: rtl/wsp_serial_driver_if.sv
// Bundle between the test controller / wrapper side and the WSP initiator.
// WSP_DRV_COMPARE_EN adds exp_data/mismatch for on-the-fly response checking.
interface wsp_serial_driver_if #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
);
  logic               start;
  logic               op_wir;
  logic [LEN_W-1:0]   shift_len;
  logic [MAX_LEN-1:0] tx_data;
  logic               wso;
  logic               SelectWIR;
  logic               CaptureWR;
  logic               ShiftWR;
  logic               UpdateWR;
  logic               wsi;
  logic [MAX_LEN-1:0] rx_data;
  logic               busy;
  logic               done;
`ifdef WSP_DRV_COMPARE_EN
  logic [MAX_LEN-1:0] exp_data;
  logic               mismatch;

  modport master (
    output start, op_wir, shift_len, tx_data, wso, exp_data,
    input  SelectWIR, CaptureWR, ShiftWR, UpdateWR, wsi, rx_data, busy, done, mismatch
  );
  modport slave (
    input  start, op_wir, shift_len, tx_data, wso, exp_data,
    output SelectWIR, CaptureWR, ShiftWR, UpdateWR, wsi, rx_data, busy, done, mismatch
  );
`else
  modport master (
    output start, op_wir, shift_len, tx_data, wso,
    input  SelectWIR, CaptureWR, ShiftWR, UpdateWR, wsi, rx_data, busy, done
  );
  modport slave (
    input  start, op_wir, shift_len, tx_data, wso,
    output SelectWIR, CaptureWR, ShiftWR, UpdateWR, wsi, rx_data, busy, done
  );
`endif
endinterface

// File: rtl/wsp_serial_driver.sv
// IEEE 1500 WSP initiator: sequences Select/Capture/Shift/Update and shifts words LSB first.
// Optional macro WSP_DRV_COMPARE_EN adds masked compare of the captured word against exp_data.
module wsp_serial_driver #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input logic                WRCK,
  input logic                WRSTN,
  wsp_serial_driver_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, CAPTURE, SHIFT, UPDATE, DONE} state_t;

  state_t             state, state_nxt;
  logic               op_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [MAX_LEN-1:0] tx_sh;
  logic [MAX_LEN-1:0] rx_sh;
  logic [MAX_LEN-1:0] rx_q;
  logic [MAX_LEN-1:0] rx_aligned;
  logic               sel_c, cap_c, sh_c, upd_c, wsi_c, busy_c, done_c;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l > LEN_W'(MAX_LEN)) return LEN_W'(MAX_LEN);
    return l;
  endfunction

  // The last len bits shifted in sit at the top of rx_sh; bring them down to bit 0.
  function automatic logic [MAX_LEN-1:0] align_rx(input logic [MAX_LEN-1:0] r,
                                                  input logic [LEN_W-1:0]   l);
    if (l == '0) return '0;
    return r >> (LEN_W'(MAX_LEN) - l);
  endfunction

  assign rx_aligned = align_rx(rx_sh, len_q);

  always_ff @(posedge WRCK or negedge WRSTN) begin
    if (!WRSTN) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SETUP;
      SETUP:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = (len_q == '0) ? UPDATE : SHIFT;
      SHIFT:   if (cnt_q == LEN_W'(1)) state_nxt = UPDATE;
      UPDATE:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_c  = 1'b0;
    cap_c  = 1'b0;
    sh_c   = 1'b0;
    upd_c  = 1'b0;
    wsi_c  = 1'b0;
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      SETUP:   begin sel_c = op_q; busy_c = 1'b1; end
      CAPTURE: begin sel_c = op_q; busy_c = 1'b1; cap_c = 1'b1; end
      SHIFT:   begin sel_c = op_q; busy_c = 1'b1; sh_c = 1'b1; wsi_c = tx_sh[0]; end
      UPDATE:  begin sel_c = op_q; busy_c = 1'b1; upd_c = 1'b1; end
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  // Operand latch and serial datapath
  always_ff @(posedge WRCK or negedge WRSTN) begin
    if (!WRSTN) begin
      op_q  <= 1'b0;
      len_q <= '0;
      cnt_q <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      rx_q  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op_q  <= bus.op_wir;
          len_q <= clamp_len(bus.shift_len);
          cnt_q <= clamp_len(bus.shift_len);
          tx_sh <= bus.tx_data;
        end
        SHIFT: begin
          tx_sh <= tx_sh >> 1;
          rx_sh <= {bus.wso, rx_sh[MAX_LEN-1:1]};
          cnt_q <= cnt_q - LEN_W'(1);
        end
        UPDATE: rx_q <= rx_aligned;
        default: ;
      endcase
    end
  end

`ifdef WSP_DRV_COMPARE_EN
  logic [MAX_LEN-1:0] exp_q;
  logic               mismatch_q;

  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
    if (l == '0) return '0;
    return {MAX_LEN{1'b1}} >> (LEN_W'(MAX_LEN) - l);
  endfunction

  always_ff @(posedge WRCK or negedge WRSTN) begin
    if (!WRSTN) begin
      exp_q      <= '0;
      mismatch_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      exp_q <= bus.exp_data;
    end else if (state == UPDATE) begin
      mismatch_q <= |((rx_aligned ^ exp_q) & len_mask(len_q));
    end
  end

  assign bus.mismatch = mismatch_q;
`endif

  assign bus.SelectWIR = sel_c;
  assign bus.CaptureWR = cap_c;
  assign bus.ShiftWR   = sh_c;
  assign bus.UpdateWR  = upd_c;
  assign bus.wsi       = wsi_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.rx_data   = rx_q;

endmodule

// File: doc/wsp_serial_driver.md
Name: wsp_serial_driver

Overview:
- Initiator side of the IEEE 1500 wrapper serial port (WSP).
- Generates SelectWIR/CaptureWR/ShiftWR/UpdateWR sequences, serializes a parallel word onto wsi, and deserializes wso into a parallel word.
- Sits between the on-chip test controller and the wrapper (WIR plus data registers). It replaces the bench-level parallel-to-serial shifter used when loading instructions.

Parameters:
- MAX_LEN, 32: widest shift supported; width of tx_data/rx_data.
- LEN_W, 6: width of shift_len; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- WRCK  input  1  wrapper clock; all state updates on the rising edge.
- WRSTN  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- op_wir  input  1  1 = WIR operation (SelectWIR asserted); 0 = data-register operation.
- shift_len  input  LEN_W  number of shift cycles, 0..MAX_LEN.
- tx_data  input  MAX_LEN  word to shift out, LSB first.
- wso  input  1  wrapper serial output from the wrapper.
- SelectWIR  output  1  wrapper select.
- CaptureWR  output  1  capture strobe.
- ShiftWR  output  1  shift enable.
- UpdateWR  output  1  update strobe.
- wsi  output  1  wrapper serial input to the wrapper.
- rx_data  output  MAX_LEN  captured word, right-justified.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (WRSTN low, asynchronous, any time including mid-operation):
  - all outputs 0, FSM to IDLE, internal shift registers and counter cleared.
  - After release, the next start runs a full operation.
- FSM states: IDLE, SETUP, CAPTURE, SHIFT, UPDATE, DONE. All outputs are registered (driven from state/regs).
- Start sampling and operand latch: start=1 in IDLE at edge k.
  - Latches op_wir, tx_data, and len = min(shift_len, MAX_LEN).
  - FSM goes to SETUP.
- Cycle timeline, counting cycles after edge k:
  - c1 SETUP: SelectWIR=op_wir, other strobes 0.
  - c2 CAPTURE: CaptureWR=1.
  - c3..c(2+len) SHIFT: ShiftWR=1. If len=0, SHIFT is skipped.
  - c(3+len) UPDATE: UpdateWR=1.
  - c(4+len) DONE: done=1, busy=0, then IDLE.
- Signal levels across the operation:
  - SelectWIR = latched op_wir from SETUP through UPDATE; 0 in IDLE and DONE.
  - busy = 1 from SETUP through UPDATE.
  - Exactly one of CaptureWR/ShiftWR/UpdateWR is high in its state, never overlapping.
- wsi:
  - Equals tx shift register bit 0 during SHIFT; the register shifts right on each SHIFT edge, so tx_data[0] goes out first.
  - wsi=0 outside SHIFT.
- rx path:
  - On each rising edge ending a SHIFT cycle: rx_shift <= {wso, rx_shift[MAX_LEN-1:1]}.
  - On the edge leaving UPDATE: rx_data <= rx_shift >> (MAX_LEN-len), right-justified with zeros above bit len-1.
  - rx_data holds until the next completion.
  - If len=0, rx_data <= 0.
- Shift counter: counts len down to 1; SHIFT exits when the counter equals 1.
- shift_len > MAX_LEN is clamped to MAX_LEN.
- start is ignored when not in IDLE (including in DONE); no queuing.
- Input changes after the start edge have no effect on the running operation.

Optional Feature:
- Macro: WSP_DRV_COMPARE_EN.
- When defined:
  - adds input exp_data [MAX_LEN] and output mismatch [1];
  - exp_data is latched with start;
  - mismatch is registered together with done as (rx_data != exp_data masked to the low len bits) and held until the next done;
  - reset value 0.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert WRSTN=0 with start=1 -> all outputs 0 and stay 0; after release, the FSM is in IDLE.
- WIR load: op_wir=1, shift_len=12, tx_data=12'b010010010010 ->
  - SelectWIR high 15 cycles; CaptureWR at c2;
  - ShiftWR c3..c14 with wsi sequence 0,1,0,0,1,0,0,1,0,0,1,0;
  - UpdateWR at c15; done at c16.
- Loopback (wso tied to wsi): op_wir=0, shift_len=8, tx_data=8'hA5 -> SelectWIR stays 0 throughout, rx_data=32'h000000A5 at done.
- shift_len=0 -> CAPTURE at c2, UPDATE at c3, ShiftWR never high, done at c4, rx_data=0.
- shift_len=40, loopback, tx_data=32'hDEADBEEF -> clamped to 32 shifts (done at c36), rx_data=32'hDEADBEEF. A second start pulse at c10 is ignored.
- Reset mid-operation: WRSTN low at c6 of a 12-bit shift -> outputs 0 immediately. A new start after release completes normally. With WSP_DRV_COMPARE_EN and loopback, exp_data=8'hA4 vs tx 8'hA5 gives mismatch=1.
